data_mem_ctrl: RTL and testbench
================================

# data_mem_ctrl

Data-memory block sitting directly downstream of the single-cycle MIPS core: it consumes the core's data-side outputs (address from the ALU result, write data, read/write strobes, byte-lane write flags) and returns read data in the same cycle. It performs byte-lane steering for SB/SH/SW and LB/LBU/LH/LHU, bounds- and alignment-checks every access, and zero-fills the whole array after reset. It exports `busy` so the top level can gate the core's `ena` until the array is clean.

## Interface
- `BASE_ADDR`, default 32'h1001_0000: byte address of word 0.
- `DEPTH`, default 2048: number of 32-bit words; power of two, ≥ 4.
- `clk`  in  1: clock; all state updates on the rising edge.
- `rst`  in  1: reset, synchronous, active-high.
- `DM_ena`  in  1: access enable; when low, no write and `DM_rdata` = 0.
- `DM_W`  in  1: write strobe.
- `DM_R`  in  1: read strobe.
- `WFLAG`  in  4: write lanes, core-relative: 4'b1111 word, 4'b0011 half, 4'b0001 byte; other values are illegal.
- `addr`  in  32: byte address, driven from `ALU_out`.
- `DM_wdata`  in  32: store data, right-justified (byte in [7:0], half in [15:0]).
- `DM_rdata`  out  32: load data, right-justified; combinational.
- `busy`  out  1: clear sweep in progress.
- `err`  out  1: sticky access-error flag.
- `err_addr`  out  32: address of the first faulting access since reset.

## Operation
- States: CLEAR, RUN.
- Reset (`rst`=1 at an edge) enters CLEAR with sweep index 0. Reset values: `busy`=1, `err`=0, `err_addr`=0. `DM_rdata` is 0 while `busy`=1.
- CLEAR writes 0 to word[index] each cycle and increments the index. After the edge that clears word DEPTH-1, the block enters RUN and `busy` drops. Core inputs are ignored during CLEAR, and no error is flagged.
- Asserting `rst` again during CLEAR or RUN restarts the sweep at index 0. A partial sweep is never resumed.
- Word index is (`addr` − `BASE_ADDR`)[31:2]. The address is in range iff `addr` − `BASE_ADDR` < 4·DEPTH, computed as an unsigned 32-bit subtraction, so addresses below the base wrap to large values and count as out of range.
- Byte offset is `off` = `addr`[1:0].
- Write, in RUN with `DM_ena` & `DM_W`:
  - Lane mask = `WFLAG` << `off`.
  - Data = `DM_wdata` << 8·`off`.
  - Only the masked bytes of word[index] are updated; the other bytes hold.
- Read, in RUN with `DM_ena` & `DM_R` & in range: `DM_rdata` = word[index] >> 8·`off`, zero-filled. The core does sign/zero extension. For LW, `off` = 0, so the full word is returned.
- Fault conditions, checked only when `DM_W` or `DM_R` is asserted:
  - Out of range.
  - `DM_W` with `WFLAG`=1111 and `off`≠0.
  - `DM_W` with `WFLAG`=0011 and `off`[0]=1.
  - `DM_W` with any illegal `WFLAG` value.
  - `DM_R` with `off`=3 is legal; only byte loads use it.
- A faulting write is fully suppressed and no bytes change. A faulting read returns 0.
- On the first fault, `err` is set and `err_addr` captures `addr`. Later faults leave both unchanged until reset.
- If `DM_W` and `DM_R` are both asserted (illegal from the core), the write commits and `DM_rdata` shows the pre-write contents.

## Timing
- Read latency is 0 cycles: `DM_rdata` is combinational from `addr`, `DM_R`, `DM_ena` and array contents, matching the single-cycle core.
- A write commits at the rising edge that ends the cycle in which it is presented. A read of the same word in the next cycle returns the new data.
- `err` and `err_addr` update at the same edge as the faulting access.
- The clear sweep lasts exactly DEPTH cycles: `busy` is high for cycles 1..DEPTH after reset release and low from cycle DEPTH+1.
- No internal pipelining: one access per cycle, no back-pressure other than `busy`.

## Test plan
- Reset sweep:
  - Stimulus: preload the array with nonzero data, then pulse `rst` for 1 cycle.
  - Response: `busy`=1 for exactly 2048 cycles; afterwards a read at 0x1001_0000 and at 0x1001_1FFC returns 0.
- Word and byte stores:
  - Stimulus: SW 0x1122_3344 at 0x1001_0010, then SB 0xAA at 0x1001_0012.
  - Response: LW of 0x1001_0010 returns 0x11AA_3344; the byte read at 0x1001_0012 returns 0x0000_00AA.
- Halfword store:
  - Stimulus: SH 0xBEEF at 0x1001_0022.
  - Response: word 0x1001_0020 = 0xBEEF_xxxx with the low half unchanged; the read at 0x1001_0022 returns 0x0000_BEEF.
- Misaligned store:
  - Stimulus: SW at 0x1001_0006.
  - Response: memory unchanged, `err`=1, `err_addr`=0x1001_0006.
  - Follow-up: a second fault at 0x1001_0001 leaves `err_addr` unchanged.
- Out of range:
  - Stimulus: LW at 0x1001_2000, then SW at 0x1000_FFFC.
  - Response: the read returns 0, no write occurs, `err`=1 with `err_addr`=0x1001_2000.
- Reset mid-sweep:
  - Stimulus: assert `rst` at sweep cycle 1000; in the same cycle drive a write (`DM_W`=1, `DM_ena`=1) to 0x1001_0000.
  - Response: the write is ignored; `busy` stays high for a full 2048 further cycles and word 0 reads 0.

Source files
------------

// File: rtl/data_mem_ctrl.sv
// -----------------------------------------------------------------------------
// data_mem_ctrl
//
// Data memory for the single-cycle MIPS core. Takes the core's data-side
// outputs, steers byte lanes for SB/SH/SW and LB/LBU/LH/LHU, and checks every
// access for range and alignment. After reset the whole array is swept to
// zero, one word per cycle, while `busy` is high.
//
// Handshake: there is no valid/ready pair. An access is "presented" in any
// cycle where DM_ena & (DM_W | DM_R) is high while busy is low. It is accepted
// unconditionally in that cycle. Writes commit at the closing rising edge.
// Reads return data combinationally in the same cycle. During the clear sweep
// (busy = 1) every access is ignored.
//
// Parameters
//   BASE_ADDR : byte address of word 0
//   DEPTH     : number of 32-bit words (power of two, >= 4)
//
// Ports
//   clk       : clock, rising edge
//   rst       : synchronous active-high reset; restarts the clear sweep
//   DM_ena    : access enable
//   DM_W      : write strobe
//   DM_R      : read strobe
//   WFLAG     : write lanes, core-relative (1111 word, 0011 half, 0001 byte)
//   addr      : byte address
//   DM_wdata  : store data, right-justified
//   DM_rdata  : load data, right-justified, zero-filled, combinational
//   busy      : clear sweep in progress
//   err       : sticky access-error flag
//   err_addr  : address of the first faulting access since reset
//   dbg_state : current FSM state (0 = CLEAR, 1 = RUN)
// -----------------------------------------------------------------------------
module data_mem_ctrl #(
    parameter logic [31:0] BASE_ADDR = 32'h1001_0000,
    parameter int          DEPTH     = 2048
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        DM_ena,
    input  logic        DM_W,
    input  logic        DM_R,
    input  logic [3:0]  WFLAG,
    input  logic [31:0] addr,
    input  logic [31:0] DM_wdata,
    output logic [31:0] DM_rdata,
    output logic        busy,
    output logic        err,
    output logic [31:0] err_addr,
    output logic        dbg_state
);

    localparam int          AW   = $clog2(DEPTH);
    localparam logic [31:0] SPAN = 32'(4 * DEPTH);

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [AW-1:0]   clr_idx;
    logic [31:0]     mem [DEPTH];

    logic [31:0]     rel;
    logic            in_range;
    logic [AW-1:0]   widx;
    logic [1:0]      off;
    logic            wflag_bad;
    logic            running;
    logic            access;
    logic            fault;
    logic            wr_en;
    logic            rd_en;
    logic [3:0]      lane_mask;
    logic [31:0]     wdata_sh;

    // Unsigned subtraction: addresses below the base wrap to large values and
    // therefore fall out of range without a separate lower-bound compare.
    assign rel      = addr - BASE_ADDR;
    assign in_range = (rel < SPAN);
    assign widx     = rel[AW+1:2];
    assign off      = addr[1:0];

    always_comb begin
        wflag_bad = 1'b1;
        case (WFLAG)
            4'b1111: wflag_bad = (off != 2'd0);
            4'b0011: wflag_bad = off[0];
            4'b0001: wflag_bad = 1'b0;
            default: wflag_bad = 1'b1;
        endcase
    end

    assign running   = (state_q == RUN);
    assign access    = running & DM_ena & (DM_W | DM_R);
    assign fault     = access & (~in_range | (DM_W & wflag_bad));
    assign wr_en     = running & DM_ena & DM_W & ~fault;
    assign rd_en     = running & DM_ena & DM_R & ~fault;

    // Only legal lane/offset pairs reach the array, so the 4-bit truncation of
    // the shifted mask never drops a lane that should be written.
    assign lane_mask = WFLAG << off;
    assign wdata_sh  = DM_wdata << {off, 3'b000};

    // Reads see the array before any write presented in the same cycle.
    assign DM_rdata  = rd_en ? (mem[widx] >> {off, 3'b000}) : 32'd0;

    assign busy      = (state_q == CLEAR);
    assign dbg_state = state_q;

    // FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            CLEAR:   if (clr_idx == AW'(DEPTH - 1)) state_d = RUN;
            RUN:     state_d = RUN;
            default: state_d = CLEAR;
        endcase
    end

    // FSM state register and sweep index
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CLEAR;
            clr_idx <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == CLEAR) clr_idx <= clr_idx + 1'b1;
        end
    end

    // Sticky error capture: only the first fault since reset is recorded.
    always_ff @(posedge clk) begin
        if (rst) begin
            err      <= 1'b0;
            err_addr <= 32'd0;
        end else if (fault && !err) begin
            err      <= 1'b1;
            err_addr <= addr;
        end
    end

    // Storage array: no reset on the array itself, the sweep zero-fills it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == CLEAR) begin
                mem[clr_idx] <= 32'd0;
            end else if (wr_en) begin
                for (int b = 0; b < 4; b++) begin
                    if (lane_mask[b]) mem[widx][8*b +: 8] <= wdata_sh[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_data_mem_ctrl
//
// Directed bench for data_mem_ctrl with hand-computed expected values.
// Inputs are driven 1 ns after a rising edge; combinational read data is
// sampled 1 ns after the inputs settle, well away from the next edge.
// -----------------------------------------------------------------------------
module tb_data_mem_ctrl;

    localparam logic [31:0] BASE  = 32'h1001_0000;
    localparam int          DEPTH = 2048;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst;
    logic        DM_ena;
    logic        DM_W;
    logic        DM_R;
    logic [3:0]  WFLAG;
    logic [31:0] addr;
    logic [31:0] DM_wdata;
    logic [31:0] DM_rdata;
    logic        busy;
    logic        err;
    logic [31:0] err_addr;
    logic        dbg_state;

    always #5 clk = ~clk;

    data_mem_ctrl #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .DM_ena    (DM_ena),
        .DM_W      (DM_W),
        .DM_R      (DM_R),
        .WFLAG     (WFLAG),
        .addr      (addr),
        .DM_wdata  (DM_wdata),
        .DM_rdata  (DM_rdata),
        .busy      (busy),
        .err       (err),
        .err_addr  (err_addr),
        .dbg_state (dbg_state)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_idle();
        DM_ena   = 1'b0;
        DM_W     = 1'b0;
        DM_R     = 1'b0;
        WFLAG    = 4'b0000;
        addr     = 32'd0;
        DM_wdata = 32'd0;
    endtask

    // One access cycle; rd is DM_rdata sampled before the closing edge.
    task automatic access(input logic [31:0] a, input logic [31:0] d, input logic [3:0] f,
                          input logic en, input logic w, input logic r,
                          output logic [31:0] rd);
        DM_ena   = en;
        DM_W     = w;
        DM_R     = r;
        WFLAG    = f;
        addr     = a;
        DM_wdata = d;
        #1;
        rd = DM_rdata;
        @(posedge clk);
        #1;
        set_idle();
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] f);
        logic [31:0] unused_rd;
        access(a, d, f, 1'b1, 1'b1, 1'b0, unused_rd);
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] data);
        access(a, 32'd0, 4'b0000, 1'b1, 1'b0, 1'b1, data);
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Counts cycles with busy high; bounded so a stuck sweep still ends.
    task automatic wait_sweep(output int n);
        n = 0;
        while (busy === 1'b1 && n < 5000) begin
            n++;
            @(posedge clk);
            #1;
        end
    endtask

    // ---------------- stimulus ----------------
    logic [31:0] r;
    int          n;

    initial begin
        set_idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Reset state
        check_eq("rst_busy", {31'd0, busy}, 32'd1);
        check_eq("rst_err", {31'd0, err}, 32'd0);
        check_eq("rst_err_addr", err_addr, 32'd0);
        check_eq("rst_state", {31'd0, dbg_state}, 32'd0);
        DM_ena = 1'b1; DM_R = 1'b1; addr = BASE;
        #1;
        check_eq("rst_rdata", DM_rdata, 32'd0);
        set_idle();
        rst = 1'b0;
        wait_sweep(n);
        check_eq("sweep0_len", n, DEPTH);
        check_eq("run_state", {31'd0, dbg_state}, 32'd1);

        // Preload then reset sweep
        wr(BASE, 32'hDEAD_BEEF, 4'b1111);
        wr(BASE + 32'h1FFC, 32'h0BAD_F00D, 4'b1111);
        rd(BASE, r);                check_eq("pre_w0", r, 32'hDEAD_BEEF);
        rd(BASE + 32'h1FFC, r);     check_eq("pre_wlast", r, 32'h0BAD_F00D);
        pulse_rst();
        wait_sweep(n);
        check_eq("sweep1_len", n, DEPTH);
        rd(BASE, r);                check_eq("clr_w0", r, 32'd0);
        rd(BASE + 32'h1FFC, r);     check_eq("clr_wlast", r, 32'd0);

        // Word and byte stores
        wr(BASE + 32'h10, 32'h1122_3344, 4'b1111);
        wr(BASE + 32'h12, 32'h0000_00AA, 4'b0001);
        rd(BASE + 32'h10, r);       check_eq("lw_10", r, 32'h11AA_3344);
        rd(BASE + 32'h12, r);       check_eq("lb_12", {24'd0, r[7:0]}, 32'h0000_00AA);
        rd(BASE + 32'h13, r);       check_eq("lb_13", r, 32'h0000_0011);

        // Halfword store
        wr(BASE + 32'h20, 32'h1234_5678, 4'b1111);
        wr(BASE + 32'h22, 32'h0000_BEEF, 4'b0011);
        rd(BASE + 32'h20, r);       check_eq("lw_20", r, 32'hBEEF_5678);
        rd(BASE + 32'h22, r);       check_eq("lh_22", r, 32'h0000_BEEF);

        // Misaligned stores
        wr(BASE + 32'h04, 32'hCAFE_F00D, 4'b1111);
        wr(BASE, 32'h5566_7788, 4'b1111);
        check_eq("no_err_yet", {31'd0, err}, 32'd0);
        wr(BASE + 32'h06, 32'hDEAD_BEEF, 4'b1111);
        check_eq("mis_err", {31'd0, err}, 32'd1);
        check_eq("mis_err_addr", err_addr, 32'h1001_0006);
        rd(BASE + 32'h04, r);       check_eq("mis_w4", r, 32'hCAFE_F00D);
        wr(BASE + 32'h01, 32'h0000_1234, 4'b0011);
        check_eq("mis2_err_addr", err_addr, 32'h1001_0006);
        rd(BASE, r);                check_eq("mis2_w0", r, 32'h5566_7788);

        // Illegal lane flag suppresses the write
        wr(BASE + 32'h30, 32'h0102_0304, 4'b1111);
        wr(BASE + 32'h30, 32'hFFFF_FFFF, 4'b0111);
        rd(BASE + 32'h30, r);       check_eq("bad_flag_w30", r, 32'h0102_0304);

        // Write and read together: read shows pre-write contents
        access(BASE + 32'h30, 32'hA5A5_A5A5, 4'b1111, 1'b1, 1'b1, 1'b1, r);
        check_eq("wr_rd_old", r, 32'h0102_0304);
        rd(BASE + 32'h30, r);       check_eq("wr_rd_new", r, 32'hA5A5_A5A5);

        // Disabled access: no read data, no write
        access(BASE + 32'h30, 32'h0, 4'b1111, 1'b0, 1'b1, 1'b1, r);
        check_eq("ena0_rdata", r, 32'd0);
        rd(BASE + 32'h30, r);       check_eq("ena0_w30", r, 32'hA5A5_A5A5);

        // Out of range
        pulse_rst();
        wait_sweep(n);
        check_eq("sweep2_len", n, DEPTH);
        check_eq("rst_clears_err", {31'd0, err}, 32'd0);
        wr(BASE + 32'h1FFC, 32'h5A5A_5A5A, 4'b1111);
        rd(BASE + 32'h1FFF, r);     check_eq("lb_top", r, 32'h0000_005A);
        rd(32'h1001_2000, r);       check_eq("oor_rdata", r, 32'd0);
        check_eq("oor_err", {31'd0, err}, 32'd1);
        check_eq("oor_err_addr", err_addr, 32'h1001_2000);
        wr(32'h1000_FFFC, 32'hFFFF_FFFF, 4'b1111);
        rd(BASE + 32'h1FFC, r);     check_eq("below_wlast", r, 32'h5A5A_5A5A);
        check_eq("below_err_addr", err_addr, 32'h1001_2000);

        // Reset mid-sweep with a write in the same cycle
        wr(BASE, 32'h7777_7777, 4'b1111);
        pulse_rst();
        repeat (999) begin
            @(posedge clk);
            #1;
        end
        check_eq("mid_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1; DM_ena = 1'b1; DM_W = 1'b1; WFLAG = 4'b1111;
        addr = BASE; DM_wdata = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        rst = 1'b0;
        set_idle();
        wait_sweep(n);
        check_eq("sweep3_len", n, DEPTH);
        rd(BASE, r);                check_eq("mid_w0", r, 32'd0);

        // ---------------- report ----------------
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
